elm_layer_sequencer: RTL and testbench

Sequencer for one ELM hidden-layer pass. It steps an input-index counter and a hidden-neuron-index counter, which address weight and input memories. It drives clear and enable strobes into the shared MAC/accumulator datapath and hands each finished neuron sum to the activation stage over a valid/ready handshake. It sits between the top-level ELM control and the hidden-layer MAC, replacing ad-hoc en_ct/rst_ct driving of the index counters.

---
 rtl/elm_pkg.sv | 19 +
 rtl/elm_layer_sequencer_if.sv | 33 +++
 rtl/elm_index_counter.sv | 31 +++
 rtl/elm_layer_sequencer.sv | 109 ++++++++++
 tb/tb_elm_layer_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/elm_pkg.sv
// Package for the ELM hidden-layer sequencer.
// Holds the sequencer state enum and the default index width / MAC latency
// shared by the sequencer, its interface and the bench.
package elm_pkg;

  localparam int unsigned ELM_IDX_W   = 4;
  localparam int unsigned ELM_MAC_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_BIAS,
    S_DRAIN,
    S_EMIT,
    S_DONE
  } elm_seq_state_t;

endpackage

// File: rtl/elm_layer_sequencer_if.sv
// Control/handshake bundle between ELM top control, the hidden-layer
// MAC datapath, the activation stage and the layer sequencer.
//   master : sequencer side (drives strobes, indices, act_valid)
//   slave  : environment side (drives start, abort, act_ready)
interface elm_layer_sequencer_if
  import elm_pkg::*;
#(
  parameter int unsigned IDX_W = ELM_IDX_W
);

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] in_idx;
  logic [IDX_W-1:0] hid_idx;
  logic             acc_clr;
  logic             mac_en;
  logic             bias_sel;
  logic             act_valid;
  logic             act_ready;

  modport master (
    input  start, abort, act_ready,
    output busy, done, in_idx, hid_idx, acc_clr, mac_en, bias_sel, act_valid
  );

  modport slave (
    output start, abort, act_ready,
    input  busy, done, in_idx, hid_idx, acc_clr, mac_en, bias_sel, act_valid
  );

endinterface

// File: rtl/elm_index_counter.sv
// Generic up-counter used for the input and hidden-neuron indices.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : advance by one
//   clr        : return to zero (wins over en)
//   term_val   : programmable terminal value
//   count      : current index
//   term       : count equals term_val
module elm_index_counter #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [IDX_W-1:0] term_val,
  output logic [IDX_W-1:0] count,
  output logic             term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + IDX_W'(1);
    end
  end

  assign term = (count == term_val);

endmodule

// File: rtl/elm_layer_sequencer.sv
// Sequencer for one ELM hidden-layer pass: walks the input index per
// neuron, strobes acc_clr / mac_en into the MAC, waits out the MAC
// pipeline, then hands the neuron sum to the activation stage via
// act_valid/act_ready. All outputs are registered.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : elm_layer_sequencer_if.master (start, abort, busy, done,
//              in_idx, hid_idx, acc_clr, mac_en, bias_sel, act_valid,
//              act_ready)
// Build option: define ELM_SEQ_BIAS_EN to add a one-cycle BIAS slot after
// the input accumulation (in_idx = N_IN, bias_sel = 1).
module elm_layer_sequencer
  import elm_pkg::*;
#(
  parameter int unsigned N_IN    = 10,
  parameter int unsigned N_HID   = 10,
  parameter int unsigned MAC_LAT = ELM_MAC_LAT,
  parameter int unsigned IDX_W   = ELM_IDX_W
) (
  input logic                   clk,
  input logic                   rst,
  elm_layer_sequencer_if.master bus
);

`ifdef ELM_SEQ_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] IN_LAST    = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] HID_LAST   = IDX_W'(N_HID - 1);
  localparam logic [2:0]       DRAIN_LAST = (MAC_LAT == 0) ? 3'd0 : 3'(MAC_LAT - 1);
  localparam elm_seq_state_t   POST_MAC   = (MAC_LAT == 0) ? S_EMIT : S_DRAIN;

  elm_seq_state_t state, state_nx;
  logic [2:0]     drain_cnt;
  logic           in_en, in_clr, in_term;
  logic           hid_en, hid_clr, hid_term;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_ACCUM;
      S_ACCUM: if (in_term) state_nx = BIAS_EN ? S_BIAS : POST_MAC;
      S_BIAS:  state_nx = POST_MAC;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nx = S_EMIT;
      S_EMIT:  if (bus.act_ready) state_nx = hid_term ? S_DONE : S_CLEAR;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // abort outranks start and the EMIT handshake
    if (bus.abort && state != S_IDLE) state_nx = S_IDLE;
  end

  // Counters follow the next state so that their value is already correct
  // in the first cycle of CLEAR/IDLE. With the bias slot the last ACCUM
  // step advances in_idx to N_IN for BIAS; otherwise it holds at N_IN-1.
  always_comb begin
    in_clr  = (state_nx == S_IDLE) || (state_nx == S_CLEAR);
    in_en   = (state == S_ACCUM) && (BIAS_EN || !in_term);
    hid_clr = (state_nx == S_IDLE);
    hid_en  = (state == S_EMIT) && bus.act_ready && !hid_term;
  end

  elm_index_counter #(.IDX_W(IDX_W)) u_in_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (in_en),
    .clr      (in_clr),
    .term_val (IN_LAST),
    .count    (bus.in_idx),
    .term     (in_term)
  );

  elm_index_counter #(.IDX_W(IDX_W)) u_hid_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (hid_en),
    .clr      (hid_clr),
    .term_val (HID_LAST),
    .count    (bus.hid_idx),
    .term     (hid_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      drain_cnt     <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.acc_clr   <= 1'b0;
      bus.mac_en    <= 1'b0;
      bus.bias_sel  <= 1'b0;
      bus.act_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      drain_cnt     <= (state == S_DRAIN && state_nx == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      bus.busy      <= (state_nx != S_IDLE);
      bus.done      <= (state_nx == S_DONE);
      bus.acc_clr   <= (state_nx == S_CLEAR);
      bus.mac_en    <= (state_nx == S_ACCUM) || (state_nx == S_BIAS);
      bus.bias_sel  <= (state_nx == S_BIAS);
      bus.act_valid <= (state_nx == S_EMIT);
    end
  end

endmodule

// File: tb/tb_elm_layer_sequencer.sv
// Self-checking bench for elm_layer_sequencer. Two instances: the default
// configuration and a minimal one (N_IN=1, N_HID=1, MAC_LAT=0). Passes use
// random act_ready stalls, stray start pulses, aborts and mid-pass resets,
// checked cycle by cycle against a timeline model of the pass.
module tb_elm_layer_sequencer;
  import elm_pkg::*;

  localparam int unsigned IDX_W = ELM_IDX_W;
`ifdef ELM_SEQ_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sel, start_r, abort_r, ready_r;
  always #5 clk = ~clk;

  elm_layer_sequencer_if #(.IDX_W(IDX_W)) bus0 ();
  elm_layer_sequencer_if #(.IDX_W(IDX_W)) bus1 ();

  // the unselected instance is held in IDLE by a permanent abort
  assign bus0.start     = start_r & ~sel;
  assign bus0.abort     = abort_r | sel;
  assign bus0.act_ready = ready_r | sel;
  assign bus1.start     = start_r & sel;
  assign bus1.abort     = abort_r | ~sel;
  assign bus1.act_ready = ready_r | ~sel;

  elm_layer_sequencer #(.N_IN(10), .N_HID(10), .MAC_LAT(2), .IDX_W(IDX_W)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  elm_layer_sequencer #(.N_IN(1), .N_HID(1), .MAC_LAT(0), .IDX_W(IDX_W)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic             o_busy, o_done, o_clr, o_mac, o_bias, o_valid;
  logic [IDX_W-1:0] o_in, o_hid;
  assign o_busy  = sel ? bus1.busy      : bus0.busy;
  assign o_done  = sel ? bus1.done      : bus0.done;
  assign o_clr   = sel ? bus1.acc_clr   : bus0.acc_clr;
  assign o_mac   = sel ? bus1.mac_en    : bus0.mac_en;
  assign o_bias  = sel ? bus1.bias_sel  : bus0.bias_sel;
  assign o_valid = sel ? bus1.act_valid : bus0.act_valid;
  assign o_in    = sel ? bus1.in_idx    : bus0.in_idx;
  assign o_hid   = sel ? bus1.hid_idx   : bus0.hid_idx;

  int n_cmp = 0;
  int n_mis = 0;
  int cur_nin, cur_nhid, cur_lat;
  int stall [16];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int per_neuron();
    return cur_nin + cur_lat + 2 + B;
  endfunction

  function automatic int pass_len();
    int s = 1;
    for (int k = 0; k < cur_nhid; k++) s += per_neuron() + stall[k];
    return s;
  endfunction

  // Expected activity in cycle t after the start edge.
  // kind: 0 idle, 1 clear, 2 accumulate, 3 bias, 4 drain, 5 emit, 6 done
  function automatic void model(input int t, output int kind, output int nrn,
                                output int idx, output bit rdy);
    int off, len, o, emit_at;
    kind = 0; nrn = 0; idx = 0; rdy = 1'b0;
    if (t < 1) return;
    off = t - 1;
    for (int k = 0; k < cur_nhid; k++) begin
      len = per_neuron() + stall[k];
      if (off < len) begin
        nrn = k;
        o = off;
        emit_at = cur_nin + 1 + B + cur_lat;
        if (o == 0) kind = 1;
        else if (o <= cur_nin) begin kind = 2; idx = o - 1; end
        else if (B == 1 && o == cur_nin + 1) begin kind = 3; idx = cur_nin; end
        else if (o < emit_at) kind = 4;
        else begin kind = 5; rdy = ((o - emit_at) >= stall[k]); end
        return;
      end
      off -= len;
    end
    if (off == 0) begin kind = 6; nrn = cur_nhid - 1; end
  endfunction

  // mode: 0 full pass, 1 abort in cycle t_stop, 2 reset in cycle t_stop
  task automatic run_pass(input int mode, input int t_stop, input bit noise);
    int kind, nrn, idx, total, first_done;
    bit rdy;
    total = pass_len();
    first_done = -1;
    @(negedge clk);
    start_r = 1'b1;
    ready_r = 1'b0;
    @(posedge clk);
    for (int t = 1; t <= total + 2; t++) begin
      @(negedge clk);
      model(t, kind, nrn, idx, rdy);
      if (mode != 0 && t > t_stop) begin kind = 0; nrn = 0; idx = 0; rdy = 1'b0; end
      ready_r = (kind == 5) ? rdy : 1'($urandom_range(0, 1));
      start_r = (noise && kind >= 1 && kind <= 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort_r = (mode == 1 && t == t_stop);
      rst     = (mode == 2 && t == t_stop);
      check_val("busy", o_busy, kind != 0);
      check_val("done", o_done, kind == 6);
      check_val("acc_clr", o_clr, kind == 1);
      check_val("mac_en", o_mac, kind == 2 || kind == 3);
      check_val("bias_sel", o_bias, kind == 3);
      check_val("act_valid", o_valid, kind == 5);
      if (kind <= 3) check_val("in_idx", int'(o_in), idx);
      if (kind != 6) check_val("hid_idx", int'(o_hid), nrn);
      if (o_done && first_done < 0) first_done = t;
    end
    check_val("done_cycle", first_done, (mode == 0) ? total : -1);
    @(negedge clk);
    start_r = 1'b0;
    abort_r = 1'b0;
    ready_r = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic clear_stalls();
    for (int k = 0; k < 16; k++) stall[k] = 0;
  endtask

  initial begin
    int total;
    rst = 1'b1; sel = 1'b0; start_r = 1'b0; abort_r = 1'b0; ready_r = 1'b0;
    clear_stalls();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check_val("rst_busy", o_busy, 0);
      check_val("rst_done", o_done, 0);
      check_val("rst_clr", o_clr, 0);
      check_val("rst_mac", o_mac, 0);
      check_val("rst_bias", o_bias, 0);
      check_val("rst_valid", o_valid, 0);
      check_val("rst_in", int'(o_in), 0);
      check_val("rst_hid", int'(o_hid), 0);
    end
    sel = 1'b0;
    rst = 1'b0;
    cur_nin = 10; cur_nhid = 10; cur_lat = 2;

    // nominal pass, then a 5-cycle stall on neuron 3
    check_val("default_len", pass_len(), 141 + 10 * B);
    run_pass(0, 0, 1'b0);
    stall[3] = 5;
    check_val("stall_len", pass_len(), 146 + 10 * B);
    run_pass(0, 0, 1'b0);
    clear_stalls();

    // abort in ACCUM of neuron 2 at in_idx 4, then a clean restart
    run_pass(1, 1 + 2 * per_neuron() + 1 + 4, 1'b0);
    run_pass(0, 0, 1'b0);

    // stray starts while busy
    run_pass(0, 0, 1'b1);

    // randomized passes, aborts and mid-pass resets
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < cur_nhid; k++) stall[k] = int'($urandom_range(0, 3));
      total = pass_len();
      run_pass(int'($urandom_range(0, 2)), int'($urandom_range(1, total - 1)), 1'($urandom_range(0, 1)));
    end
    clear_stalls();
    run_pass(2, 20, 1'b0);
    run_pass(0, 0, 1'b0);

    // minimal configuration
    sel = 1'b1;
    cur_nin = 1; cur_nhid = 1; cur_lat = 0;
    repeat (2) @(posedge clk);
    check_val("min_len", pass_len(), 4 + B);
    run_pass(0, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      stall[0] = int'($urandom_range(0, 4));
      total = pass_len();
      run_pass(int'($urandom_range(0, 1)), int'($urandom_range(1, total - 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
